fr_adder_norm: RTL and testbench

Post-add normalization stage of the floating-point MAC adder path, directly downstream of the fraction pre-adder. It consumes the registered sign and the two pre-conditioned 24-bit fractions, together with the common exponent and an effective-subtract flag. It forms the fraction sum and renormalizes it iteratively, one left shift per cycle, using an FSM with valid/ready handshakes on both sides. It emits a normalized sign, exponent and 24-bit fraction (hidden bit included) with overflow and underflow flags.

---
 rtl/fr_pkg.sv | 16 +
 rtl/fr_adder_norm.sv | 172 +++++++++++++++++
 tb/tb_fr_adder_norm.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fr_pkg.sv
// Shared definitions for the post-add normalization stage of the FP MAC adder path.
package fr_pkg;

  localparam int FRAC_W = 24;
  localparam int EXP_W  = 8;

  localparam logic [EXP_W-1:0] EXP_INF = {EXP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fr_adder_norm.sv
// Post-add normalization: sums two pre-conditioned fractions, then renormalizes
// one left shift per cycle, with valid/ready handshakes on both sides.
module fr_adder_norm
  import fr_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic              in_sub,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_input1,
  input  logic [FRAC_W-1:0] in_input2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_ovf,
  output logic              out_unf
);

  state_t state_q, state_d;

  logic              sign_q, sign_d;
  logic              sub_q, sub_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [FRAC_W-1:0] a_q, a_d;
  logic [FRAC_W-1:0] b_q, b_d;
  logic [FRAC_W-1:0] frac_q, frac_d;

  logic              out_sign_q, out_sign_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [FRAC_W-1:0] out_frac_q, out_frac_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_unf_q, out_unf_d;

  logic [FRAC_W:0]   sum;
  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  exp_dec;
  logic [FRAC_W-1:0] frac_shl;

  // The shift that lands the leading one in the MSB also moves to DONE, so a
  // single-shift result costs one extra cycle over the no-shift case.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    exp_d      = exp_q;
    a_d        = a_q;
    b_d        = b_q;
    frac_d     = frac_q;
    out_sign_d = out_sign_q;
    out_exp_d  = out_exp_q;
    out_frac_d = out_frac_q;
    out_ovf_d  = out_ovf_q;
    out_unf_d  = out_unf_q;
    sum        = {1'b0, a_q} + {1'b0, b_q};
    exp_inc    = exp_q + 1'b1;
    exp_dec    = exp_q - 1'b1;
    frac_shl   = {frac_q[FRAC_W-2:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          sub_d   = in_sub;
          exp_d   = in_exp;
          a_d     = in_input1;
          b_d     = in_input2;
          state_d = ADD;
        end
      end

      ADD: begin
        out_sign_d = sign_q;
        out_exp_d  = exp_q;
        out_frac_d = sum[FRAC_W-1:0];
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        state_d    = DONE;
        if (!sub_q && sum[FRAC_W]) begin
          out_exp_d = exp_inc;
          if (exp_inc == EXP_INF) begin
            out_frac_d = '0;
            out_ovf_d  = 1'b1;
          end else begin
            out_frac_d = sum[FRAC_W:1];
          end
        end else if (sub_q && (sum[FRAC_W-1:0] == '0)) begin
          out_sign_d = 1'b0;
          out_exp_d  = '0;
        end else if (sub_q && !sum[FRAC_W-1]) begin
          frac_d  = sum[FRAC_W-1:0];
          state_d = NORM;
        end
      end

      NORM: begin
        out_sign_d = sign_q;
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        if (frac_q[FRAC_W-1]) begin
          out_exp_d  = exp_q;
          out_frac_d = frac_q;
          state_d    = DONE;
        end else if (exp_q[EXP_W-1:1] == '0) begin
          out_exp_d  = '0;
          out_frac_d = '0;
          out_unf_d  = 1'b1;
          state_d    = DONE;
        end else begin
          frac_d = frac_shl;
          exp_d  = exp_dec;
          if (frac_q[FRAC_W-2]) begin
            out_exp_d  = exp_dec;
            out_frac_d = frac_shl;
            state_d    = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      frac_q     <= '0;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_frac_q <= '0;
      out_ovf_q  <= 1'b0;
      out_unf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      exp_q      <= exp_d;
      a_q        <= a_d;
      b_q        <= b_d;
      frac_q     <= frac_d;
      out_sign_q <= out_sign_d;
      out_exp_q  <= out_exp_d;
      out_frac_q <= out_frac_d;
      out_ovf_q  <= out_ovf_d;
      out_unf_q  <= out_unf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fr_adder_norm.sv
// Directed-vector bench for fr_adder_norm: table of hand-computed results plus
// handshake, backpressure and mid-operation reset sequences.
module tb_fr_adder_norm;
  import fr_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic              in_sub;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W-1:0] in_input1;
  logic [FRAC_W-1:0] in_input2;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [FRAC_W-1:0] out_frac;
  logic              out_ovf;
  logic              out_unf;

  int n_vec    = 0;
  int n_err    = 0;
  int n_checks = 0;

  typedef struct {
    logic              sub;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] in1;
    logic [FRAC_W-1:0] in2;
    logic              e_sign;
    logic [EXP_W-1:0]  e_exp;
    logic [FRAC_W-1:0] e_frac;
    logic              e_ovf;
    logic              e_unf;
    int                e_lat;
  } vec_t;

  vec_t vecs[13];

  fr_adder_norm dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_sub    (in_sub),
    .in_exp    (in_exp),
    .in_input1 (in_input1),
    .in_input2 (in_input2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Present one operation and return once the accepting edge has passed.
  task automatic startOp(input vec_t v);
    int waited;
    @(negedge clock);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("in_ready before accept", in_ready, 1);
    in_valid  = 1'b1;
    in_sub    = v.sub;
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_input1 = v.in1;
    in_input2 = v.in2;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accepting cycle as cycle 1.
  task automatic applyStimulus(input vec_t v, output int lat);
    startOp(v);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    n_vec++;
  endtask

  task automatic checkResult(input string tag, input vec_t v, input int lat);
    checkOutput({tag, " latency"}, lat, v.e_lat);
    checkOutput({tag, " out_valid"}, out_valid, 1);
    checkOutput({tag, " in_ready busy"}, in_ready, 0);
    checkOutput({tag, " out_sign"}, out_sign, v.e_sign);
    checkOutput({tag, " out_exp"}, out_exp, v.e_exp);
    checkOutput({tag, " out_frac"}, out_frac, v.e_frac);
    checkOutput({tag, " out_ovf"}, out_ovf, v.e_ovf);
    checkOutput({tag, " out_unf"}, out_unf, v.e_unf);
  endtask

  task automatic releaseResult(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput({tag, " out_valid after accept"}, out_valid, 0);
    checkOutput({tag, " in_ready after accept"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    //          sub   sign  exp    in1           in2           sign  exp    frac          ovf   unf  lat
    vecs[0]  = '{1'b0, 1'b0, 8'd127, 24'h800000, 24'h800000, 1'b0, 8'd128, 24'h800000, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b1, 1'b0, 8'd127, 24'hC00000, 24'h800000, 1'b0, 8'd126, 24'h800000, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 8'd127, 24'hA00000, 24'h600000, 1'b0, 8'd0,   24'h000000, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b0, 1'b0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 8'd255, 24'h000000, 1'b1, 1'b0, 2};
    vecs[4]  = '{1'b1, 1'b0, 8'd1,   24'hC00000, 24'h800000, 1'b0, 8'd0,   24'h000000, 1'b0, 1'b1, 3};
    vecs[5]  = '{1'b0, 1'b1, 8'd100, 24'h400000, 24'h200000, 1'b1, 8'd100, 24'h600000, 1'b0, 1'b0, 2};
    vecs[6]  = '{1'b1, 1'b1, 8'd50,  24'hF00000, 24'hF00000, 1'b1, 8'd50,  24'hE00000, 1'b0, 1'b0, 2};
    vecs[7]  = '{1'b1, 1'b0, 8'd130, 24'h800010, 24'h800000, 1'b0, 8'd111, 24'h800000, 1'b0, 1'b0, 21};
    vecs[8]  = '{1'b1, 1'b0, 8'd3,   24'hC00000, 24'h500000, 1'b0, 8'd0,   24'h000000, 1'b0, 1'b1, 5};
    vecs[9]  = '{1'b1, 1'b1, 8'd10,  24'hA00000, 24'h800000, 1'b1, 8'd8,   24'h800000, 1'b0, 1'b0, 4};
    vecs[10] = '{1'b1, 1'b0, 8'd20,  24'hC12345, 24'h900000, 1'b0, 8'd19,  24'hA2468A, 1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 1'b0, 8'd5,   24'hC00001, 24'hC00002, 1'b0, 8'd6,   24'hC00001, 1'b0, 1'b0, 2};
    vecs[12] = '{1'b1, 1'b1, 8'd77,  24'h123456, 24'hEDCBAA, 1'b0, 8'd0,   24'h000000, 1'b0, 1'b0, 2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_sub    = 1'b0;
    in_exp    = '0;
    in_input1 = '0;
    in_input2 = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_sign", out_sign, 0);
    checkOutput("reset out_exp", out_exp, 0);
    checkOutput("reset out_frac", out_frac, 0);
    checkOutput("reset out_ovf", out_ovf, 0);
    checkOutput("reset out_unf", out_unf, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], lat);
      checkResult($sformatf("vec%0d", i), vecs[i], lat);
      releaseResult($sformatf("vec%0d", i));
    end

    // Backpressure: DONE and outputs held while out_ready stays low; in_valid ignored.
    applyStimulus(vecs[1], lat);
    checkResult("hold start", vecs[1], lat);
    @(negedge clock);
    in_valid  = 1'b1;
    in_sub    = 1'b0;
    in_exp    = 8'd9;
    in_input1 = 24'h123456;
    in_input2 = 24'h654321;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      checkResult($sformatf("hold cycle%0d", c), vecs[1], lat);
    end
    @(negedge clock);
    in_valid = 1'b0;
    releaseResult("hold");

    // out_ready already high: DONE lasts exactly one cycle.
    @(negedge clock);
    out_ready = 1'b1;
    applyStimulus(vecs[0], lat);
    checkResult("early ready", vecs[0], lat);
    @(posedge clock);
    #1;
    checkOutput("early ready out_valid drop", out_valid, 0);
    checkOutput("early ready in_ready back", in_ready, 1);
    out_ready = 1'b0;

    // Reset in the middle of a long normalization discards the operation.
    startOp(vecs[7]);
    n_vec++;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midreset in_ready", in_ready, 1);
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset out_exp", out_exp, 0);
    checkOutput("midreset out_frac", out_frac, 0);
    checkOutput("midreset out_sign", out_sign, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("midreset no out_valid", seen, 0);
    checkOutput("midreset idle", in_ready, 1);

    applyStimulus(vecs[10], lat);
    checkResult("after reset", vecs[10], lat);
    releaseResult("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
